// File: rtl/branch_pkg.sv
// Shared branch-prediction types and constants, also used by the branch waterfall queue.
// The BRANCH_GSHARE_EN macro adds a history snapshot to each in-flight entry.
package branch_pkg;

  localparam int BP_INDEX_BITS  = 5;
  localparam int BP_QUEUE_DEPTH = 3;

  typedef logic [1:0] bp_counter_t;

  localparam bp_counter_t SNT = 2'd0;
  localparam bp_counter_t WNT = 2'd1;
  localparam bp_counter_t WT  = 2'd2;
  localparam bp_counter_t ST  = 2'd3;

  typedef struct packed {
`ifdef BRANCH_GSHARE_EN
    logic [BP_INDEX_BITS-1:0] history;
`endif
    logic [BP_INDEX_BITS-1:0] index;
  } bp_fifo_entry_t;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic bp_counter_t bp_train(input bp_counter_t cnt, input logic taken);
    bp_counter_t result;
    result = cnt;
    if (taken && cnt != ST) begin
      result = cnt + 2'd1;
    end else if (!taken && cnt != SNT) begin
      result = cnt - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bp_index_fifo.sv
// Circular FIFO holding one record per in-flight branch; flush empties it and
// wins over a same-cycle push. Pop on empty and push on full (without pop) are dropped.
module bp_index_fifo
  import branch_pkg::*;
#(
  parameter int DATA_W = BP_INDEX_BITS,
  parameter int DEPTH  = BP_QUEUE_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_history_predictor.sv
// Fetch-stage 2-bit-counter branch direction predictor, trained in program order at resolve.
// Define BRANCH_GSHARE_EN to XOR a global history register into the table index.
module branch_history_predictor
  import branch_pkg::*;
#(
  parameter int INDEX_BITS  = BP_INDEX_BITS,
  parameter int QUEUE_DEPTH = BP_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        fetch_valid,
  input  logic        fetch_is_branch,
  input  logic [15:0] fetch_pc,
  input  logic [15:0] fetch_offset,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic        resolve_correct,
  output logic        prediction_out,
  output logic [15:0] predicted_pc,
  output logic [15:0] mispredict_address_out,
  output logic        load_prediction,
  output logic        branch_ready
);

  localparam int TABLE_SIZE = 1 << INDEX_BITS;
`ifdef BRANCH_GSHARE_EN
  localparam int ENTRY_W = 2 * INDEX_BITS;
`else
  localparam int ENTRY_W = INDEX_BITS;
`endif

  bp_counter_t           ctr_q [TABLE_SIZE];
  logic [INDEX_BITS-1:0] pc_index;
  logic [INDEX_BITS-1:0] fetch_index;
  logic [INDEX_BITS-1:0] head_index;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic [15:0]           seq_pc;
  logic [15:0]           target_pc;
  logic                  pred_taken;
  logic                  branch_fetch;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  resolve_fire;
  logic                  mispredict;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[15:INDEX_BITS+1], fetch_pc[0]};

  assign seq_pc     = fetch_pc + 16'd2;
  assign target_pc  = seq_pc + fetch_offset;
  assign pc_index   = fetch_pc[INDEX_BITS:1];
  assign head_index = head_entry[INDEX_BITS-1:0];

`ifdef BRANCH_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;
  logic [INDEX_BITS-1:0] head_snapshot;

  assign fetch_index   = pc_index ^ ghr_q;
  assign push_entry    = {ghr_q, fetch_index};
  assign head_snapshot = head_entry[ENTRY_W-1:INDEX_BITS];

  // Mispredict repairs history to the path actually taken, overriding any speculative shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (mispredict) begin
      ghr_q <= {head_snapshot[INDEX_BITS-2:0], resolve_taken};
    end else if (load_prediction) begin
      ghr_q <= {ghr_q[INDEX_BITS-2:0], pred_taken};
    end
  end
`else
  assign fetch_index = pc_index;
  assign push_entry  = fetch_index;
`endif

  // Prediction reads the registered counter only: a same-cycle training write is not bypassed.
  assign pred_taken   = ctr_q[fetch_index][1];
  assign branch_fetch = fetch_valid & fetch_is_branch;

  always_comb begin
    prediction_out         = 1'b0;
    predicted_pc           = seq_pc;
    mispredict_address_out = 16'h0000;
    if (branch_fetch) begin
      prediction_out         = pred_taken;
      predicted_pc           = pred_taken ? target_pc : seq_pc;
      mispredict_address_out = pred_taken ? seq_pc : target_pc;
    end
  end

  // Handshake: a branch transfers when load_prediction is high, i.e. a valid branch fetch
  // while branch_ready and not stalled. branch_ready is high when a slot is free or the head
  // is retiring correctly this cycle; fetch must hold the branch while branch_ready is low.
  assign branch_ready    = ~fifo_full | (resolve_valid & resolve_correct);
  assign load_prediction = branch_fetch & branch_ready & ~stall;

  assign resolve_fire = resolve_valid & ~stall & ~fifo_empty;
  assign mispredict   = resolve_fire & ~resolve_correct;

  bp_index_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (QUEUE_DEPTH)
  ) u_index_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (load_prediction),
    .pop       (resolve_fire),
    .flush     (mispredict),
    .push_data (push_entry),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (resolve_fire) begin
      ctr_q[head_index] <= bp_train(ctr_q[head_index], resolve_taken);
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Bench for branch_history_predictor: directed vector table plus random stimulus
// checked against a queue-based reference model.
module tb_branch_history_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        fetch_valid;
  logic        fetch_is_branch;
  logic [15:0] fetch_pc;
  logic [15:0] fetch_offset;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        resolve_correct;
  logic        prediction_out;
  logic [15:0] predicted_pc;
  logic [15:0] mispredict_address_out;
  logic        load_prediction;
  logic        branch_ready;

  localparam int W = 35;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: counters as ints, in-flight branches as queues.
  int mdl_ctr[32];
  int mdl_idx_q[$];
  int mdl_snap_q[$];
  int mdl_ghr;

  typedef struct {
    logic        fv, fb;
    logic [15:0] pc, off;
    logic        rv, rt, rc, st;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_history_predictor dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .stall                  (stall),
    .fetch_valid            (fetch_valid),
    .fetch_is_branch        (fetch_is_branch),
    .fetch_pc               (fetch_pc),
    .fetch_offset           (fetch_offset),
    .resolve_valid          (resolve_valid),
    .resolve_taken          (resolve_taken),
    .resolve_correct        (resolve_correct),
    .prediction_out         (prediction_out),
    .predicted_pc           (predicted_pc),
    .mispredict_address_out (mispredict_address_out),
    .load_prediction        (load_prediction),
    .branch_ready           (branch_ready)
  );

  wire [W-1:0] dut_word = {prediction_out, predicted_pc, mispredict_address_out,
                           load_prediction, branch_ready};

  function automatic logic [W-1:0] ew(input logic p, input logic [15:0] ppc,
                                      input logic [15:0] mis, input logic ld, input logic rdy);
    return {p, ppc, mis, ld, rdy};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_word(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    logic [W-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got pred=%b ppc=%h mis=%h load=%b ready=%b, expected pred=%b ppc=%h mis=%h load=%b ready=%b",
               name, got[34], got[33:18], got[17:2], got[1], got[0],
               e[34], e[33:18], e[17:2], e[1], e[0]);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl_ctr[i] = 1;
    mdl_idx_q.delete();
    mdl_snap_q.delete();
    mdl_ghr = 0;
  endtask

  function automatic int mdl_index(input logic [15:0] pc);
    int idx;
    idx = (int'(pc) / 2) % 32;
`ifdef BRANCH_GSHARE_EN
    idx = idx ^ mdl_ghr;
`endif
    return idx;
  endfunction

  function automatic logic [W-1:0] model_expect();
    int idx;
    logic taken, br, ready, load;
    logic [15:0] seq, tgt;
    idx   = mdl_index(fetch_pc);
    taken = (mdl_ctr[idx] >= 2);
    seq   = fetch_pc + 16'd2;
    tgt   = seq + fetch_offset;
    br    = fetch_valid && fetch_is_branch;
    ready = (mdl_idx_q.size() < 3) || (resolve_valid && resolve_correct);
    load  = br && ready && !stall;
    return ew(br && taken, (br && taken) ? tgt : seq,
              br ? (taken ? seq : tgt) : 16'h0000, load, ready);
  endfunction

  task automatic model_step();
    logic [W-1:0] o;
    int idx, h, s;
    if (stall) return;
    o   = model_expect();
    idx = mdl_index(fetch_pc);
    if (resolve_valid && mdl_idx_q.size() > 0) begin
      h = mdl_idx_q.pop_front();
      s = mdl_snap_q.pop_front();
      if (resolve_taken) mdl_ctr[h] = (mdl_ctr[h] == 3) ? 3 : mdl_ctr[h] + 1;
      else               mdl_ctr[h] = (mdl_ctr[h] == 0) ? 0 : mdl_ctr[h] - 1;
      if (!resolve_correct) begin
        mdl_idx_q.delete();
        mdl_snap_q.delete();
        mdl_ghr = ((s * 2) + int'(resolve_taken)) % 32;
        return;
      end
    end
    if (o[1]) begin
      mdl_idx_q.push_back(idx);
      mdl_snap_q.push_back(mdl_ghr);
      mdl_ghr = ((mdl_ghr * 2) + int'(o[34])) % 32;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cycle(input logic fv, input logic fb, input logic [15:0] pc,
                           input logic [15:0] off, input logic rv, input logic rt,
                           input logic rc, input logic st, input logic use_exp,
                           input logic [W-1:0] exp, input string name);
    fetch_valid     = fv;
    fetch_is_branch = fb;
    fetch_pc        = pc;
    fetch_offset    = off;
    resolve_valid   = rv;
    resolve_taken   = rt;
    resolve_correct = rc;
    stall           = st;
    @(negedge clk);
    if (use_exp) check_word(name, dut_word, exp);
    else         check_word(name, dut_word, model_expect());
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [15:0] pc, input string name);
    stall         = 1'b1;
    fetch_valid   = 1'b0;
    resolve_valid = 1'b0;
    fetch_pc      = pc;
    rst_n         = 1'b0;
    #2;
    check_word(name, dut_word, ew(1'b0, pc + 16'd2, 16'h0000, 1'b0, 1'b1));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic fv, input logic fb, input logic [15:0] pc,
                              input logic [15:0] off, input logic rv, input logic rt,
                              input logic rc, input logic st, input logic [W-1:0] exp);
    vec_t v;
    v.fv = fv; v.fb = fb; v.pc = pc; v.off = off;
    v.rv = rv; v.rt = rt; v.rc = rc; v.st = st; v.exp = exp;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    fetch_valid     = 1'b0;
    fetch_is_branch = 1'b0;
    fetch_pc        = 16'h1234;
    fetch_offset    = 16'h0000;
    resolve_valid   = 1'b0;
    resolve_taken   = 1'b0;
    resolve_correct = 1'b0;
    model_reset();
    #12;
    check_word("reset_outputs", dut_word, ew(1'b0, 16'h1236, 16'h0000, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifndef BRANCH_GSHARE_EN
    //                fv fb pc        off       rv rt rc st  expected {pred, ppc, mis, load, ready}
    vecs.push_back(mk(0, 0, 16'h0010, 16'h0020, 0, 0, 0, 0, ew(0, 16'h0012, 16'h0000, 0, 1)));
    vecs.push_back(mk(1, 1, 16'h0010, 16'h0020, 0, 0, 0, 0, ew(0, 16'h0012, 16'h0032, 1, 1)));
    vecs.push_back(mk(0, 0, 16'h0010, 16'h0020, 1, 1, 1, 0, ew(0, 16'h0012, 16'h0000, 0, 1)));
    vecs.push_back(mk(1, 1, 16'h0010, 16'h0020, 0, 0, 0, 0, ew(1, 16'h0032, 16'h0012, 1, 1)));
    vecs.push_back(mk(0, 0, 16'h0010, 16'h0020, 1, 1, 1, 0, ew(0, 16'h0012, 16'h0000, 0, 1)));
    vecs.push_back(mk(1, 1, 16'h0010, 16'h0020, 0, 0, 0, 0, ew(1, 16'h0032, 16'h0012, 1, 1)));
    vecs.push_back(mk(1, 1, 16'h0020, 16'h0004, 0, 0, 0, 0, ew(0, 16'h0022, 16'h0026, 1, 1)));
    vecs.push_back(mk(1, 1, 16'h0030, 16'hFFF0, 0, 0, 0, 0, ew(0, 16'h0032, 16'h0022, 1, 1)));
    vecs.push_back(mk(1, 1, 16'h0040, 16'h0000, 0, 0, 0, 0, ew(0, 16'h0042, 16'h0042, 0, 0)));
    vecs.push_back(mk(1, 1, 16'h0040, 16'h0000, 1, 1, 1, 0, ew(0, 16'h0042, 16'h0042, 1, 1)));
    vecs.push_back(mk(0, 0, 16'h0010, 16'h0020, 1, 0, 1, 0, ew(0, 16'h0012, 16'h0000, 0, 1)));
    vecs.push_back(mk(1, 1, 16'h0010, 16'h0020, 1, 1, 0, 0, ew(1, 16'h0032, 16'h0012, 1, 1)));
    vecs.push_back(mk(1, 1, 16'h0030, 16'hFFF0, 0, 0, 0, 0, ew(1, 16'h0022, 16'h0032, 1, 1)));
    vecs.push_back(mk(1, 1, 16'h0020, 16'h0004, 0, 0, 0, 0, ew(0, 16'h0022, 16'h0026, 1, 1)));
    vecs.push_back(mk(1, 1, 16'hFFFE, 16'h0004, 0, 0, 0, 0, ew(0, 16'h0000, 16'h0004, 1, 1)));
    vecs.push_back(mk(1, 1, 16'h0030, 16'hFFF0, 1, 1, 1, 1, ew(1, 16'h0022, 16'h0032, 0, 1)));
    vecs.push_back(mk(0, 0, 16'h0030, 16'hFFF0, 0, 0, 0, 0, ew(0, 16'h0032, 16'h0000, 0, 0)));
    vecs.push_back(mk(1, 0, 16'h0030, 16'hFFF0, 1, 1, 1, 0, ew(0, 16'h0032, 16'h0000, 0, 1)));
    vecs.push_back(mk(0, 0, 16'h0010, 16'h0020, 1, 0, 0, 0, ew(0, 16'h0012, 16'h0000, 0, 1)));
    vecs.push_back(mk(0, 0, 16'h0010, 16'h0020, 1, 1, 1, 0, ew(0, 16'h0012, 16'h0000, 0, 1)));
    vecs.push_back(mk(1, 1, 16'h0010, 16'h0020, 0, 0, 0, 0, ew(1, 16'h0032, 16'h0012, 1, 1)));
    vecs.push_back(mk(1, 1, 16'h0030, 16'hFFF0, 0, 0, 0, 0, ew(1, 16'h0022, 16'h0032, 1, 1)));
    foreach (vecs[i]) begin
      run_cycle(vecs[i].fv, vecs[i].fb, vecs[i].pc, vecs[i].off, vecs[i].rv, vecs[i].rt,
                vecs[i].rc, vecs[i].st, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
    end
`endif

    // Reset with state in flight, then confirm the trained entry is back to weakly not-taken.
    run_cycle(1, 1, 16'h0010, 16'h0020, 0, 0, 0, 0, 1'b0, '0, "pre_reset_load");
    apply_reset(16'h0100, "midrun_reset");
    run_cycle(1, 1, 16'h0010, 16'h0020, 0, 0, 0, 0, 1'b1,
              ew(0, 16'h0012, 16'h0032, 1, 1), "post_reset_fetch");

    for (int i = 0; i < 3000; i++) begin
      logic fv, fb, rv, rt, rc, st;
      logic [15:0] pc, off;
      fv  = ($urandom_range(0, 9) < 7);
      fb  = ($urandom_range(0, 9) < 7);
      pc  = 16'($urandom_range(0, 47)) << 1;
      if ($urandom_range(0, 19) == 0) pc = 16'hFFFE;
      off = 16'($urandom);
      rv  = (mdl_idx_q.size() > 0) && ($urandom_range(0, 9) < 4);
      rt  = ($urandom_range(0, 9) < 6);
      rc  = ($urandom_range(0, 9) < 8);
      st  = ($urandom_range(0, 9) == 0);
      run_cycle(fv, fb, pc, off, rv, rt, rc, st, 1'b0, '0, "random");
      if (i == 1500) apply_reset(pc, "random_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
